bus_demux: RTL and testbench

BUS_DEMUX -- requirements
Module: bus_demux

---
 rtl/bus_demux.sv | 130 +++++++++++++
 tb/tb_bus_demux.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_demux.sv
// -----------------------------------------------------------------------------
// bus_demux
//
// Purpose:
//   Demultiplexes one valid/ready upstream word stream onto DATA_NUM downstream
//   channels. Each channel owns a 2-entry FIFO whose head word is presented on
//   that channel's slice of down_data. The word is routed according to up_gate.
//
// Configuration macro:
//   BUS_DEMUX_BROADCAST_EN
//     defined   : every set bit of up_gate receives the word in one transfer.
//     undefined : only the lowest set bit of up_gate is used; others ignored.
//
// Ports:
//   clk         in   single clock, rising-edge
//   rst         in   synchronous active-high reset
//   up_gate     in   [DATA_NUM-1:0]            channel select, bit i -> channel i
//   up_valid    in   upstream word valid
//   up_data     in   [DATA_WIDTH-1:0]          upstream word
//   up_ready    out  upstream word accepted when up_valid & up_ready
//   down_valid  out  [DATA_NUM-1:0]            channel i head word valid
//   down_data   out  [DATA_WIDTH*DATA_NUM-1:0] channel i at [(i+1)*W-1 : i*W]
//   down_ready  in   [DATA_NUM-1:0]            channel i consumer takes head
// -----------------------------------------------------------------------------
module bus_demux #(
    parameter int DATA_WIDTH = 16,
    parameter int DATA_NUM   = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [DATA_NUM-1:0]            up_gate,
    input  logic                           up_valid,
    input  logic [DATA_WIDTH-1:0]          up_data,
    output logic                           up_ready,
    output logic [DATA_NUM-1:0]            down_valid,
    output logic [DATA_WIDTH*DATA_NUM-1:0] down_data,
    input  logic [DATA_NUM-1:0]            down_ready
);

    // Per-channel FIFO storage: head is what the consumer sees, tail is the
    // second entry (only meaningful when count is 2).
    logic [DATA_WIDTH-1:0] head_q  [DATA_NUM];
    logic [DATA_WIDTH-1:0] head_d  [DATA_NUM];
    logic [DATA_WIDTH-1:0] tail_q  [DATA_NUM];
    logic [DATA_WIDTH-1:0] tail_d  [DATA_NUM];
    logic [1:0]            count_q [DATA_NUM];
    logic [1:0]            count_d [DATA_NUM];

    logic [DATA_NUM-1:0] effGate;
    logic [DATA_NUM-1:0] chanFull;
    logic [DATA_NUM-1:0] pushCh;
    logic [DATA_NUM-1:0] popCh;
    logic                xfer;

    // Effective select. In single-target mode, x & -x isolates the lowest
    // set bit so higher gate bits never reach a channel.
`ifdef BUS_DEMUX_BROADCAST_EN
    assign effGate = up_gate;
`else
    assign effGate = up_gate & (~up_gate + DATA_NUM'(1));
`endif

    // Status flags and the head/valid outputs come straight from registers,
    // so nothing on up_* can reach down_* combinationally.
    for (genvar g = 0; g < DATA_NUM; g++) begin : gChan
        assign chanFull[g]                                = (count_q[g] == 2'd2);
        assign down_valid[g]                              = (count_q[g] != 2'd0);
        assign down_data[g*DATA_WIDTH +: DATA_WIDTH]      = head_q[g];
    end

    // Upstream may only proceed when every targeted channel has room; reset
    // forces it low so nothing is accepted while state is being cleared.
    assign up_ready = !rst && (|effGate) && !(|(effGate & chanFull));
    assign xfer     = up_valid && up_ready;
    assign pushCh   = {DATA_NUM{xfer}} & effGate;
    assign popCh    = down_valid & down_ready;

    // Next-state for each channel FIFO. At count 1 a simultaneous push and
    // pop replaces the head directly; at count 2 a pop promotes the tail.
    // A push at count 2 cannot occur because up_ready excludes full channels.
    always_comb begin
        for (int i = 0; i < DATA_NUM; i++) begin
            head_d[i]  = head_q[i];
            tail_d[i]  = tail_q[i];
            count_d[i] = count_q[i];
            case (count_q[i])
                2'd0: begin
                    if (pushCh[i]) begin
                        head_d[i]  = up_data;
                        count_d[i] = 2'd1;
                    end
                end
                2'd1: begin
                    if (pushCh[i] && popCh[i]) begin
                        head_d[i]  = up_data;
                    end else if (pushCh[i]) begin
                        tail_d[i]  = up_data;
                        count_d[i] = 2'd2;
                    end else if (popCh[i]) begin
                        count_d[i] = 2'd0;
                    end
                end
                default: begin
                    if (popCh[i]) begin
                        head_d[i]  = tail_q[i];
                        count_d[i] = 2'd1;
                    end
                end
            endcase
        end
    end

    // State registers; reset clears counts and zeroes the visible data.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DATA_NUM; i++) begin
                head_q[i]  <= '0;
                tail_q[i]  <= '0;
                count_q[i] <= 2'd0;
            end
        end else begin
            for (int i = 0; i < DATA_NUM; i++) begin
                head_q[i]  <= head_d[i];
                tail_q[i]  <= tail_d[i];
                count_q[i] <= count_d[i];
            end
        end
    end

endmodule

// File: tb/tb_bus_demux.sv
// -----------------------------------------------------------------------------
// tb_bus_demux
//
// Purpose:
//   Self-checking bench for bus_demux (DATA_WIDTH=16, DATA_NUM=4). A queue per
//   channel models the FIFOs; directed scenarios use fixed expected values and
//   a randomized phase compares against the queue model every cycle.
//   Honours BUS_DEMUX_BROADCAST_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_bus_demux;

    localparam int DW  = 16;
    localparam int NUM = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NUM-1:0]    upGate;
    logic              upValid;
    logic [DW-1:0]     upData;
    logic              upReady;
    logic [NUM-1:0]    downValid;
    logic [DW*NUM-1:0] downData;
    logic [NUM-1:0]    downReady;

    int compareCount = 0;
    int failCount    = 0;

    // Reference model: one queue of words per channel.
    logic [DW-1:0] modelQ [NUM][$];

    bus_demux #(.DATA_WIDTH(DW), .DATA_NUM(NUM)) dut (
        .clk        (clk),
        .rst        (rst),
        .up_gate    (upGate),
        .up_valid   (upValid),
        .up_data    (upData),
        .up_ready   (upReady),
        .down_valid (downValid),
        .down_data  (downData),
        .down_ready (downReady)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    // Which channels a given gate value writes to.
    function automatic logic [NUM-1:0] modelEffGate(input logic [NUM-1:0] g);
`ifdef BUS_DEMUX_BROADCAST_EN
        return g;
`else
        for (int i = 0; i < NUM; i++) begin
            if (g[i]) return NUM'(1) << i;
        end
        return '0;
`endif
    endfunction

    // Expected up_ready from queue occupancy and the current inputs.
    function automatic logic modelReady();
        logic [NUM-1:0] eff;
        if (rst) return 1'b0;
        eff = modelEffGate(upGate);
        if (eff == '0) return 1'b0;
        for (int i = 0; i < NUM; i++) begin
            if (eff[i] && modelQ[i].size() >= 2) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic logic [NUM-1:0] modelValid();
        logic [NUM-1:0] v;
        for (int i = 0; i < NUM; i++) v[i] = (modelQ[i].size() > 0);
        return v;
    endfunction

    function automatic logic [DW-1:0] slice(input int ch);
        return downData[ch*DW +: DW];
    endfunction

    // Drive inputs away from the clock edge and let combinational paths settle.
    task automatic applyStimulus(input logic [NUM-1:0] g, input logic v,
                                 input logic [DW-1:0] d, input logic [NUM-1:0] r);
        upGate    = g;
        upValid   = v;
        upData    = d;
        downReady = r;
        #1;
    endtask

    // Take one rising edge, update the model with what the edge should do,
    // and land just after the edge for sampling.
    task automatic advanceClock();
        logic           acc;
        logic [NUM-1:0] eff;
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < NUM; i++) modelQ[i].delete();
        end else begin
            acc = upValid && modelReady();
            eff = modelEffGate(upGate);
            for (int i = 0; i < NUM; i++) begin
                if (modelQ[i].size() > 0 && downReady[i]) void'(modelQ[i].pop_front());
            end
            if (acc) begin
                for (int i = 0; i < NUM; i++) if (eff[i]) modelQ[i].push_back(upData);
            end
        end
        #1;
    endtask

    task automatic drainAll();
        applyStimulus('0, 1'b0, '0, '1);
        advanceClock();
        advanceClock();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        applyStimulus(4'b0001, 1'b1, 16'hFFFF, '1);
        advanceClock();
        advanceClock();
        compareCount++;
        if (upReady !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL reset_up_ready: got %b expected 0", upReady);
        end
        compareCount++;
        if (downValid !== 4'b0000) begin
            failCount++;
            $display("[TB] FAIL reset_down_valid: got %b expected 0000", downValid);
        end
        compareCount++;
        if (downData !== '0) begin
            failCount++;
            $display("[TB] FAIL reset_down_data: got %h expected 0", downData);
        end
        rst = 1'b0;
        applyStimulus(4'b0001, 1'b0, '0, '0);
        compareCount++;
        if (upReady !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL post_reset_ready: got %b expected 1", upReady);
        end
    endtask

    task automatic test_single();
        applyStimulus(4'b0010, 1'b1, 16'hA5A5, '0);
        advanceClock();
        applyStimulus(4'b0010, 1'b0, '0, '0);
        compareCount++;
        if (downValid !== 4'b0010) begin
            failCount++;
            $display("[TB] FAIL single_valid: got %b expected 0010", downValid);
        end
        compareCount++;
        if (slice(1) !== 16'hA5A5) begin
            failCount++;
            $display("[TB] FAIL single_data: got %h expected a5a5", slice(1));
        end
        compareCount++;
        if (upReady !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL single_ready: got %b expected 1", upReady);
        end
        drainAll();
    endtask

    task automatic test_fill_drain();
        logic [DW-1:0] expHeads [3] = '{16'h0001, 16'h0002, 16'h0003};
        applyStimulus(4'b0001, 1'b1, 16'h0001, '0);
        advanceClock();
        applyStimulus(4'b0001, 1'b1, 16'h0002, '0);
        compareCount++;
        if (upReady !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL fill_second_ready: got %b expected 1", upReady);
        end
        advanceClock();
        applyStimulus(4'b0001, 1'b1, 16'h0003, '0);
        compareCount++;
        if (upReady !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL fill_full_ready: got %b expected 0", upReady);
        end
        advanceClock();
        // Keep offering 0003 while draining; it enters once a slot frees.
        for (int k = 0; k < 3; k++) begin
            applyStimulus(4'b0001, (k < 2), 16'h0003, 4'b0001);
            compareCount++;
            if (downValid[0] !== 1'b1 || slice(0) !== expHeads[k]) begin
                failCount++;
                $display("[TB] FAIL drain_head%0d: got v=%b d=%h expected v=1 d=%h",
                         k, downValid[0], slice(0), expHeads[k]);
            end
            advanceClock();
        end
        applyStimulus('0, 1'b0, '0, '0);
        compareCount++;
        if (downValid !== 4'b0000) begin
            failCount++;
            $display("[TB] FAIL drain_empty: got %b expected 0000", downValid);
        end
    endtask

    task automatic test_push_pop();
        applyStimulus(4'b0001, 1'b1, 16'h00AA, '0);
        advanceClock();
        applyStimulus(4'b0001, 1'b1, 16'h00BB, 4'b0001);
        compareCount++;
        if (upReady !== 1'b1 || slice(0) !== 16'h00AA) begin
            failCount++;
            $display("[TB] FAIL pushpop_before: got r=%b d=%h expected r=1 d=00aa", upReady, slice(0));
        end
        advanceClock();
        applyStimulus('0, 1'b0, '0, '0);
        compareCount++;
        if (downValid !== 4'b0001 || slice(0) !== 16'h00BB) begin
            failCount++;
            $display("[TB] FAIL pushpop_after: got v=%b d=%h expected v=0001 d=00bb", downValid, slice(0));
        end
        applyStimulus('0, 1'b0, '0, 4'b0001);
        advanceClock();
        compareCount++;
        if (downValid !== 4'b0000) begin
            failCount++;
            $display("[TB] FAIL pushpop_count1: got %b expected 0000", downValid);
        end
    endtask

    task automatic test_gate_multi();
        applyStimulus(4'b0110, 1'b1, 16'h1234, '0);
        advanceClock();
        applyStimulus('0, 1'b0, '0, '0);
`ifdef BUS_DEMUX_BROADCAST_EN
        compareCount++;
        if (downValid !== 4'b0110 || slice(1) !== 16'h1234 || slice(2) !== 16'h1234) begin
            failCount++;
            $display("[TB] FAIL multi_gate: got v=%b d1=%h d2=%h expected v=0110 d=1234",
                     downValid, slice(1), slice(2));
        end
`else
        compareCount++;
        if (downValid !== 4'b0010 || slice(1) !== 16'h1234) begin
            failCount++;
            $display("[TB] FAIL multi_gate: got v=%b d1=%h expected v=0010 d1=1234",
                     downValid, slice(1));
        end
`endif
        drainAll();
    endtask

    task automatic test_zero_gate();
        applyStimulus(4'b1000, 1'b1, 16'h7777, '0);
        advanceClock();
        for (int k = 0; k < 5; k++) begin
            applyStimulus(4'b0000, 1'b1, 16'h5555, '0);
            compareCount++;
            if (upReady !== 1'b0) begin
                failCount++;
                $display("[TB] FAIL zero_gate_ready%0d: got %b expected 0", k, upReady);
            end
            advanceClock();
            compareCount++;
            if (downValid !== 4'b1000 || slice(3) !== 16'h7777) begin
                failCount++;
                $display("[TB] FAIL zero_gate_hold%0d: got v=%b d3=%h expected v=1000 d3=7777",
                         k, downValid, slice(3));
            end
        end
        drainAll();
    endtask

    task automatic test_reset_mid();
        applyStimulus(4'b1000, 1'b1, 16'h3001, '0);
        advanceClock();
        applyStimulus(4'b1000, 1'b1, 16'h3002, '0);
        advanceClock();
        applyStimulus(4'b0100, 1'b1, 16'h2001, '0);
        advanceClock();
        applyStimulus(4'b0100, 1'b1, 16'h2002, '0);
        advanceClock();
        applyStimulus(4'b1000, 1'b1, 16'h3003, '0);
        compareCount++;
        if (downValid !== 4'b1100 || upReady !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL mid_full: got v=%b r=%b expected v=1100 r=0", downValid, upReady);
        end
        rst = 1'b1;
        applyStimulus(4'b1000, 1'b1, 16'h3003, '1);
        advanceClock();
        compareCount++;
        if (downValid !== 4'b0000 || downData !== '0) begin
            failCount++;
            $display("[TB] FAIL mid_reset: got v=%b d=%h expected v=0000 d=0", downValid, downData);
        end
        rst = 1'b0;
        applyStimulus(4'b1000, 1'b1, 16'hC0DE, '0);
        compareCount++;
        if (upReady !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL mid_after_ready: got %b expected 1", upReady);
        end
        advanceClock();
        applyStimulus('0, 1'b0, '0, '0);
        compareCount++;
        if (downValid !== 4'b1000 || slice(3) !== 16'hC0DE) begin
            failCount++;
            $display("[TB] FAIL mid_after_word: got v=%b d3=%h expected v=1000 d3=c0de",
                     downValid, slice(3));
        end
        drainAll();
    endtask

    task automatic test_random();
        logic [NUM-1:0] expV;
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 79) == 0);
            applyStimulus(NUM'($urandom), ($urandom_range(0, 3) != 0),
                          DW'($urandom), NUM'($urandom));
            compareCount++;
            if (upReady !== modelReady()) begin
                failCount++;
                $display("[TB] FAIL rand_ready@%0d: got %b expected %b", n, upReady, modelReady());
            end
            expV = modelValid();
            compareCount++;
            if (downValid !== expV) begin
                failCount++;
                $display("[TB] FAIL rand_valid@%0d: got %b expected %b", n, downValid, expV);
            end
            for (int i = 0; i < NUM; i++) begin
                if (modelQ[i].size() > 0) begin
                    compareCount++;
                    if (slice(i) !== modelQ[i][0]) begin
                        failCount++;
                        $display("[TB] FAIL rand_data%0d@%0d: got %h expected %h",
                                 i, n, slice(i), modelQ[i][0]);
                    end
                end
            end
            advanceClock();
        end
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        upGate    = '0;
        upValid   = 1'b0;
        upData    = '0;
        downReady = '0;
        test_reset();
        test_single();
        test_fill_drain();
        test_push_pop();
        test_gate_multi();
        test_zero_gate();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
